// File: rtl/axis_ola_inv_pkg.sv
// Shared definitions for the overlap-add stage: default geometry, derived
// accumulator/address widths and the one-hot control state encodings.
package axis_ola_inv_pkg;

    localparam int OLA_SAMPLE_WIDTH = 16;
    localparam int OLA_FFT_SIZE     = 4096;
    localparam int OLA_HOP_SIZE     = 2048;
    localparam int OLA_ADDR_WIDTH   = $clog2(OLA_FFT_SIZE);
    localparam int OLA_ACC_WIDTH    = OLA_SAMPLE_WIDTH + $clog2(OLA_FFT_SIZE / OLA_HOP_SIZE);

    // One-hot control states
    localparam logic [2:0] OLA_ST_CLEAR   = 3'b001;
    localparam logic [2:0] OLA_ST_RUN_OUT = 3'b010;
    localparam logic [2:0] OLA_ST_RUN_ACC = 3'b100;

endpackage

// File: rtl/ola_acc_ram.sv
// Simple dual-port accumulator RAM: one write port, one read port with a
// clock enable and one cycle of read latency. Contents are never reset.
module ola_acc_ram
    import axis_ola_inv_pkg::*;
#(
    parameter int DEPTH      = OLA_FFT_SIZE,
    parameter int ADDR_WIDTH = OLA_ADDR_WIDTH,
    parameter int DATA_WIDTH = OLA_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; the output register belongs to the RAM macro
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axis_ola_inv.sv
// Overlap-add stage after the IFFT. Frames of FFT_SIZE samples are summed,
// HOP_SIZE apart, into a circular accumulator; HOP_SIZE finished samples are
// streamed out per frame.
// Build option: define OLA_SAT_EN to saturate outputs to the sample range;
// otherwise outputs are the low SAMPLE_WIDTH bits of the sum.
module axis_ola_inv
    import axis_ola_inv_pkg::*;
#(
    parameter int SAMPLE_WIDTH = OLA_SAMPLE_WIDTH,
    parameter int FFT_SIZE     = OLA_FFT_SIZE,
    parameter int HOP_SIZE     = OLA_HOP_SIZE,
    parameter int ACC_WIDTH    = SAMPLE_WIDTH + $clog2(FFT_SIZE / HOP_SIZE)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    axis_ifft2ola_tvalid,
    output logic                    axis_ifft2ola_tready,
    input  logic [SAMPLE_WIDTH-1:0] axis_ifft2ola_tdata,
    input  logic                    axis_ifft2ola_tlast,
    input  logic [1:0]              axis_ifft2ola_tkeep,
    output logic                    axis_ola2out_tvalid,
    input  logic                    axis_ola2out_tready,
    output logic [SAMPLE_WIDTH-1:0] axis_ola2out_tdata,
    output logic                    axis_ola2out_tlast,
    output logic                    ola_busy,
    output logic                    ola_frame_err
);

    localparam int              AW         = $clog2(FFT_SIZE);
    localparam logic [AW-1:0]   K_LAST     = AW'(FFT_SIZE - 1);
    localparam logic [AW-1:0]   K_HOP_LAST = AW'(HOP_SIZE - 1);
    localparam logic [AW-1:0]   HOP_STEP   = AW'(HOP_SIZE);

    logic [2:0]              state;
    logic [AW-1:0]           k;
    logic [AW-1:0]           base;
    logic [AW-1:0]           clr_cnt;
    logic                    adv;
    logic                    accept;
    logic                    frame_mismatch;
    logic [AW-1:0]           addr;

    logic                    s1_valid;
    logic                    s1_out;
    logic                    s1_last;
    logic [SAMPLE_WIDTH-1:0] s1_data;
    logic [AW-1:0]           s1_addr;
    logic [ACC_WIDTH-1:0]    sum;

    logic                    s2_valid;
    logic                    s2_out;
    logic                    s2_last;
    logic [ACC_WIDTH-1:0]    s2_sum;
    logic [AW-1:0]           s2_addr;
    logic [SAMPLE_WIDTH-1:0] out_val;

    logic [ACC_WIDTH-1:0]    ram_rd_data;
    logic                    ram_wr_en;
    logic [AW-1:0]           ram_wr_addr;
    logic [ACC_WIDTH-1:0]    ram_wr_data;

    logic                    unused_tkeep;

    assign unused_tkeep         = ^axis_ifft2ola_tkeep;
    assign adv                  = !axis_ola2out_tvalid | axis_ola2out_tready;
    assign axis_ifft2ola_tready = adv & !ola_busy;
    assign accept               = axis_ifft2ola_tvalid & axis_ifft2ola_tready;
    assign frame_mismatch       = accept & (axis_ifft2ola_tlast ^ (k == K_LAST));
    assign addr                 = base + k;
    assign sum = {{(ACC_WIDTH - SAMPLE_WIDTH){s1_data[SAMPLE_WIDTH-1]}}, s1_data} + ram_rd_data;

`ifdef OLA_SAT_EN
    logic [ACC_WIDTH-SAMPLE_WIDTH:0] sum_hi;
    assign sum_hi = s2_sum[ACC_WIDTH-1:SAMPLE_WIDTH-1];

    // Clamp when the bits above the sample sign disagree with it
    always_comb begin
        out_val = s2_sum[SAMPLE_WIDTH-1:0];
        if (!(&sum_hi) && (|sum_hi)) begin
            out_val = s2_sum[ACC_WIDTH-1] ? {1'b1, {(SAMPLE_WIDTH-1){1'b0}}}
                                          : {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
        end
    end
`else
    assign out_val = s2_sum[SAMPLE_WIDTH-1:0];
`endif

    // Control: clear sweep, frame position k, circular base, frame check
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= OLA_ST_CLEAR;
            k             <= '0;
            base          <= '0;
            clr_cnt       <= '0;
            ola_busy      <= 1'b1;
            ola_frame_err <= 1'b0;
        end else begin
            ola_frame_err <= frame_mismatch;
            case (state)
                OLA_ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == K_LAST) begin
                        state    <= OLA_ST_RUN_OUT;
                        ola_busy <= 1'b0;
                    end
                end
                OLA_ST_RUN_OUT: begin
                    if (accept) begin
                        k <= k + 1'b1;
                        if (k == K_HOP_LAST) begin
                            state <= OLA_ST_RUN_ACC;
                        end
                    end
                end
                OLA_ST_RUN_ACC: begin
                    if (accept) begin
                        if (k == K_LAST) begin
                            k     <= '0;
                            base  <= base + HOP_STEP;
                            state <= OLA_ST_RUN_OUT;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= OLA_ST_CLEAR;
                    clr_cnt  <= '0;
                    ola_busy <= 1'b1;
                end
            endcase
        end
    end

    // Three-stage datapath, all stages advance together on adv
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid            <= 1'b0;
            s1_out              <= 1'b0;
            s1_last             <= 1'b0;
            s1_data             <= '0;
            s1_addr             <= '0;
            s2_valid            <= 1'b0;
            s2_out              <= 1'b0;
            s2_last             <= 1'b0;
            s2_sum              <= '0;
            s2_addr             <= '0;
            axis_ola2out_tvalid <= 1'b0;
            axis_ola2out_tdata  <= '0;
            axis_ola2out_tlast  <= 1'b0;
        end else if (adv) begin
            s1_valid            <= accept;
            s1_out              <= (state == OLA_ST_RUN_OUT);
            s1_last             <= (state == OLA_ST_RUN_OUT) && (k == K_HOP_LAST);
            s1_data             <= axis_ifft2ola_tdata;
            s1_addr             <= addr;
            s2_valid            <= s1_valid;
            s2_out              <= s1_out;
            s2_last             <= s1_last;
            s2_sum              <= sum;
            s2_addr             <= s1_addr;
            axis_ola2out_tvalid <= s2_valid & s2_out;
            axis_ola2out_tlast  <= s2_valid & s2_out & s2_last;
            if (s2_valid && s2_out) begin
                axis_ola2out_tdata <= out_val;
            end
        end
    end

    // RAM write port: clear sweep, else stage-2 writeback (0 once emitted)
    always_comb begin
        ram_wr_en   = adv & s2_valid;
        ram_wr_addr = s2_addr;
        ram_wr_data = s2_out ? '0 : s2_sum;
        if (state == OLA_ST_CLEAR) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = clr_cnt;
            ram_wr_data = '0;
        end
    end

    ola_acc_ram #(
        .DEPTH      (FFT_SIZE),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (ACC_WIDTH)
    ) u_acc_ram (
        .clk     (clk),
        .rd_en   (adv),
        .rd_addr (addr),
        .rd_data (ram_rd_data),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data)
    );

endmodule

// File: tb/tb_axis_ola_inv.sv
// Directed bench for axis_ola_inv at the default geometry (N=4096, H=2048).
module tb_axis_ola_inv;

    localparam int N = 4096;
    localparam int H = 2048;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [15:0] i_tdata = '0;
    logic        i_tlast = 1'b0;
    logic [1:0]  i_tkeep = 2'b11;
    logic        o_tvalid;
    logic        o_tready = 1'b1;
    logic [15:0] o_tdata;
    logic        o_tlast;
    logic        busy;
    logic        frame_err;

    always #5 clk = ~clk;

    axis_ola_inv dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .axis_ifft2ola_tvalid (i_tvalid),
        .axis_ifft2ola_tready (i_tready),
        .axis_ifft2ola_tdata  (i_tdata),
        .axis_ifft2ola_tlast  (i_tlast),
        .axis_ifft2ola_tkeep  (i_tkeep),
        .axis_ola2out_tvalid  (o_tvalid),
        .axis_ola2out_tready  (o_tready),
        .axis_ola2out_tdata   (o_tdata),
        .axis_ola2out_tlast   (o_tlast),
        .ola_busy             (busy),
        .ola_frame_err        (frame_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int neg_cnt  = 0;
    int first_acc = -1;
    int err_cnt  = 0;
    bit abort    = 0;
    logic [15:0] out_q[$];
    logic        out_last_q[$];
    int          out_neg_q[$];
    logic [15:0] exp_q[$];
    int          acc_model[N];

    // Monitor: record output handshakes, first input accept, error pulses
    always @(negedge clk) begin
        if (reset_n) begin
            if (o_tvalid && o_tready) begin
                out_q.push_back(o_tdata);
                out_last_q.push_back(o_tlast);
                out_neg_q.push_back(neg_cnt);
            end
            if (i_tvalid && i_tready && first_acc < 0) first_acc = neg_cnt;
            if (frame_err) err_cnt++;
        end
        neg_cnt++;
    end

    function automatic logic [15:0] fold(input int s);
`ifdef OLA_SAT_EN
        if (s > 32767)  return 16'h7fff;
        if (s < -32768) return 16'h8000;
`endif
        return 16'(s);
    endfunction

    task automatic clear_mon();
        out_q.delete();
        out_last_q.delete();
        out_neg_q.delete();
        first_acc = -1;
        err_cnt = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0; i_tvalid = 1'b0; i_tlast = 1'b0; i_tdata = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 5000 && busy; i++) @(negedge clk);
        @(posedge clk); #1;
        clear_mon();
    endtask

    task automatic send(input logic [15:0] x, input logic last, input int unsigned gap_pct);
        int n;
        if (abort) return;
        while (gap_pct != 0 && $urandom_range(99) < gap_pct) begin
            i_tvalid = 1'b0;
            @(posedge clk); #1;
        end
        i_tvalid = 1'b1; i_tdata = x; i_tlast = last;
        n = 0;
        forever begin
            @(negedge clk);
            if (i_tready) break;
            n++;
            if (n > 2000) begin
                n_checks++; n_fail++;
                $display("FAIL input_accept_timeout: tready=%0b after %0d cycles, want 1", i_tready, n);
                abort = 1;
                break;
            end
        end
        @(posedge clk); #1;
        i_tvalid = 1'b0; i_tlast = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] v, input int extra_last);
        for (int k = 0; k < N; k++) send(v, (k == N-1) || (k == extra_last), 0);
    endtask

    task automatic wait_out(input int n);
        for (int i = 0; i < 40000 && out_q.size() < n; i++) @(negedge clk);
        repeat (8) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int busy_cycles = 0;
        int tr_bad = 0;
        @(posedge clk); #1 reset_n = 1'b0;
        #2;
        n_checks++; if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %0b want 0", o_tvalid); end
        n_checks++; if (o_tdata !== 16'd0) begin n_fail++; $display("FAIL reset_tdata: got %0d want 0", o_tdata); end
        n_checks++; if (o_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %0b want 0", o_tlast); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %0b want 1", busy); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %0b want 0", frame_err); end
        n_checks++; if (i_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %0b want 0", i_tready); end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cycles++;
            if (i_tready) tr_bad++;
        end
        n_checks++; if (busy_cycles != 4096) begin n_fail++; $display("FAIL busy_cycles: got %0d want 4096", busy_cycles); end
        n_checks++; if (tr_bad != 0) begin n_fail++; $display("FAIL tready_while_busy: got %0d cycles want 0", tr_bad); end
        n_checks++; if (i_tready !== 1'b1) begin n_fail++; $display("FAIL tready_after_clear: got %0b want 1", i_tready); end
        @(posedge clk); #1;
        clear_mon();
    endtask

    task automatic test_single_frame();
        send_frame(16'd100, -1);
        wait_out(H);
        n_checks++; if (out_q.size() != H) begin n_fail++; $display("FAIL single_count: got %0d want %0d", out_q.size(), H); end
        for (int i = 0; i < out_q.size(); i++) begin
            n_checks++; if (out_q[i] !== 16'd100) begin n_fail++; $display("FAIL single_data[%0d]: got %0d want 100", i, $signed(out_q[i])); end
            n_checks++; if (out_last_q[i] !== (i == H-1)) begin n_fail++; $display("FAIL single_tlast[%0d]: got %0b want %0b", i, out_last_q[i], (i == H-1)); end
        end
        n_checks++;
        if (out_neg_q.size() == 0 || out_neg_q[0] - first_acc != 3) begin
            n_fail++;
            $display("FAIL single_latency: got %0d negedges want 3", (out_neg_q.size() == 0) ? -1 : out_neg_q[0] - first_acc);
        end
        n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL single_frame_err: got %0d pulses want 0", err_cnt); end
    endtask

    task automatic test_overlap();
        clear_mon();
        send_frame(16'd100, -1);
        send_frame(16'd100, -1);
        wait_out(2*H);
        n_checks++; if (out_q.size() != 2*H) begin n_fail++; $display("FAIL overlap_count: got %0d want %0d", out_q.size(), 2*H); end
        for (int i = 0; i < out_q.size(); i++) begin
            n_checks++; if (out_q[i] !== 16'd200) begin n_fail++; $display("FAIL overlap_data[%0d]: got %0d want 200", i, $signed(out_q[i])); end
            n_checks++; if (out_last_q[i] !== ((i % H) == H-1)) begin n_fail++; $display("FAIL overlap_tlast[%0d]: got %0b", i, out_last_q[i]); end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] want;
        do_reset();
        send_frame(16'd30000, -1);
        send_frame(16'd30000, -1);
        wait_out(2*H);
        n_checks++; if (out_q.size() != 2*H) begin n_fail++; $display("FAIL sat_count: got %0d want %0d", out_q.size(), 2*H); end
        for (int i = 0; i < out_q.size(); i++) begin
`ifdef OLA_SAT_EN
            want = (i < H) ? 16'd30000 : 16'h7fff;
`else
            want = (i < H) ? 16'd30000 : 16'hea60;
`endif
            n_checks++; if (out_q[i] !== want) begin n_fail++; $display("FAIL sat_data[%0d]: got %0d want %0d", i, $signed(out_q[i]), $signed(want)); end
        end
    endtask

    task automatic test_random_stall();
        logic [15:0] data[$];
        bit done;
        int base, a, s;
        do_reset();
        for (int i = 0; i < N; i++) acc_model[i] = 0;
        exp_q.delete();
        base = 0;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < N; k++) begin
                logic [15:0] x;
                x = 16'($urandom);
                data.push_back(x);
                a = (base + k) % N;
                s = acc_model[a] + int'($signed(x));
                if (k < H) begin
                    exp_q.push_back(fold(s));
                    acc_model[a] = 0;
                end else begin
                    acc_model[a] = s;
                end
            end
            base = (base + H) % N;
        end
        done = 0;
        fork
            begin
                for (int i = 0; i < 2*N; i++) send(data[i], (i % N) == N-1, 25);
                done = 1;
            end
            begin
                while (!done) begin
                    o_tready = ($urandom_range(99) >= 30);
                    @(posedge clk); #1;
                end
                o_tready = 1'b1;
            end
        join
        wait_out(exp_q.size());
        n_checks++; if (out_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stall_count: got %0d want %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (out_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_data[%0d]: got %0d want %0d", i, $signed(out_q[i]), $signed(exp_q[i])); end
            n_checks++; if (out_last_q[i] !== ((i % H) == H-1)) begin n_fail++; $display("FAIL stall_tlast[%0d]: got %0b", i, out_last_q[i]); end
        end
        n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL stall_frame_err: got %0d pulses want 0", err_cnt); end
    endtask

    task automatic test_frame_err();
        do_reset();
        send_frame(16'd7, 100);
        wait_out(H);
        n_checks++; if (err_cnt != 1) begin n_fail++; $display("FAIL frame_err_pulses: got %0d want 1", err_cnt); end
        n_checks++; if (out_q.size() != H) begin n_fail++; $display("FAIL frame_err_count: got %0d want %0d", out_q.size(), H); end
        for (int i = 0; i < out_q.size(); i++) begin
            n_checks++; if (out_q[i] !== 16'd7) begin n_fail++; $display("FAIL frame_err_data[%0d]: got %0d want 7", i, $signed(out_q[i])); end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_mon();
        for (int k = 0; k < 3000; k++) send(16'd50, 1'b0, 0);
        reset_n = 1'b0;
        #1;
        n_checks++; if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_tvalid: got %0b want 0", o_tvalid); end
        n_checks++; if (o_tdata !== 16'd0) begin n_fail++; $display("FAIL mid_reset_tdata: got %0d want 0", o_tdata); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_reset_busy: got %0b want 1", busy); end
        n_checks++; if (i_tready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_tready: got %0b want 0", i_tready); end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 5000 && busy; i++) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_clear_done: busy=%0b want 0", busy); end
        @(posedge clk); #1;
        clear_mon();
        send_frame(16'd9, -1);
        wait_out(H);
        n_checks++; if (out_q.size() != H) begin n_fail++; $display("FAIL post_reset_count: got %0d want %0d", out_q.size(), H); end
        for (int i = 0; i < out_q.size(); i++) begin
            n_checks++; if (out_q[i] !== 16'd9) begin n_fail++; $display("FAIL post_reset_data[%0d]: got %0d want 9", i, $signed(out_q[i])); end
        end
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_frame();
        test_overlap();
        test_saturation();
        test_random_stall();
        test_frame_err();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
